// File: rtl/frogger_rand_pkg.sv
// Shared types and helpers for the Frogger random-number arbiter.
// Holds the LFSR step function and the lockup-seed guard.
package frogger_rand_pkg;

    localparam int unsigned LFSR_W = 10;
    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 10'h3FF;
    localparam logic [LFSR_W-1:0] LFSR_SAFE   = 10'h000;

    typedef enum logic {
        RUN    = 1'b0,
        RESEED = 1'b1
    } state_t;

    // One XNOR LFSR step, shifting right with feedback into the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {~(v[0] ^ v[3]), v[LFSR_W-1:1]};
    endfunction

    // The all-ones pattern locks an XNOR LFSR, so it is swapped for a safe value.
    function automatic logic [LFSR_W-1:0] lfsr_sanitize(input logic [LFSR_W-1:0] v);
        return (v == LFSR_LOCKUP) ? LFSR_SAFE : v;
    endfunction

endpackage

// File: rtl/lfsr_rand_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
// Indices are wrapped explicitly, so non-power-of-2 requester counts stay in range.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] eff_req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick_c,
    output logic [PTR_W-1:0]   pick_idx_c,
    output logic               any_c
);

    always_comb begin
        int unsigned j;
        j          = 0;
        pick_c     = '0;
        pick_idx_c = '0;
        any_c      = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = 32'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any_c && eff_req[PTR_W'(j)]) begin
                any_c               = 1'b1;
                pick_c[PTR_W'(j)]   = 1'b1;
                pick_idx_c          = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// Shares one 10-bit XNOR LFSR round-robin among NUM_REQ requesters.
// Each grant returns the pre-step LFSR value and advances it once; supports reseeding.
module lfsr_rand_arbiter
    import frogger_rand_pkg::*;
#(
    parameter int unsigned       NUM_REQ  = 4,
    parameter logic [LFSR_W-1:0] SEED     = 10'h000,
    parameter bit                FREE_RUN = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [LFSR_W-1:0]  rand_out,
    output logic               rand_valid,
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed_in,
    output logic               busy
);

    localparam int unsigned       PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [LFSR_W-1:0] SEED_SAFE = lfsr_sanitize(SEED);

    state_t              state;
    state_t              state_d;
    logic [LFSR_W-1:0]   lfsr;
    logic [LFSR_W-1:0]   lfsr_d;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_d;
    logic [NUM_REQ-1:0]  gnt_d;
    logic [LFSR_W-1:0]   rand_out_d;
    logic                rand_valid_d;
    logic                busy_d;

    logic [NUM_REQ-1:0]  eff_req;
    logic [NUM_REQ-1:0]  pick;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any;

    // A requester is masked during its own grant cycle.
    assign eff_req = req & ~gnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .eff_req    (eff_req),
        .ptr        (ptr),
        .pick_c     (pick),
        .pick_idx_c (pick_idx),
        .any_c      (pick_any)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        lfsr_d       = lfsr;
        ptr_d        = ptr;
        gnt_d        = '0;
        rand_out_d   = rand_out;
        rand_valid_d = 1'b0;
        busy_d       = 1'b0;
        case (state)
            RUN: begin
                if (seed_load) begin
                    state_d = RESEED;
                    busy_d  = 1'b1;
                    lfsr_d  = lfsr_sanitize(seed_in);
                end else if (pick_any) begin
                    gnt_d        = pick;
                    rand_out_d   = lfsr;
                    rand_valid_d = 1'b1;
                    lfsr_d       = lfsr_next(lfsr);
                    ptr_d        = (pick_idx == PTR_LAST) ? '0 : PTR_W'(pick_idx + PTR_W'(1));
                end else if (FREE_RUN) begin
                    lfsr_d = lfsr_next(lfsr);
                end
            end
            RESEED: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            lfsr       <= SEED_SAFE;
            ptr        <= '0;
            gnt        <= '0;
            rand_out   <= '0;
            rand_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            lfsr       <= lfsr_d;
            ptr        <= ptr_d;
            gnt        <= gnt_d;
            rand_out   <= rand_out_d;
            rand_valid <= rand_valid_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Bench for lfsr_rand_arbiter: a 4-requester instance and a 3-requester free-running one
// share stimulus and are compared every cycle against an arithmetic reference model.
module tb_lfsr_rand_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req4;
    logic [2:0] req3;
    logic       seed_load;
    logic [9:0] seed_in;

    logic [3:0] gnt4;
    logic [9:0] rand4;
    logic       valid4;
    logic       busy4;
    logic [2:0] gnt3;
    logic [9:0] rand3;
    logic       valid3;
    logic       busy3;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state, index 0 = 4-requester, index 1 = 3-requester.
    int m_lfsr[2];
    int m_ptr[2];
    int m_gnt[2];
    int m_rand[2];
    int m_valid[2];
    int m_busy[2];
    int m_reseed[2];
    int m_n[2]    = '{4, 3};
    int m_free[2] = '{0, 1};
    int m_seed[2] = '{'h000, 'h3FF};

    int eg4[5] = '{1, 2, 4, 8, 1};
    int er4[5] = '{'h000, 'h200, 'h300, 'h380, 'h3C0};
    int eg3[4] = '{1, 2, 4, 1};

    always #5 clk = ~clk;

    lfsr_rand_arbiter #(
        .NUM_REQ  (4),
        .SEED     (10'h000),
        .FREE_RUN (1'b0)
    ) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .req        (req4),
        .gnt        (gnt4),
        .rand_out   (rand4),
        .rand_valid (valid4),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .busy       (busy4)
    );

    lfsr_rand_arbiter #(
        .NUM_REQ  (3),
        .SEED     (10'h3FF),
        .FREE_RUN (1'b1)
    ) u_dut3 (
        .clk        (clk),
        .reset      (reset),
        .req        (req3),
        .gnt        (gnt3),
        .rand_out   (rand3),
        .rand_valid (valid3),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .busy       (busy3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int safe_seed(input int v);
        return (v == 'h3FF) ? 0 : v;
    endfunction

    // XNOR of bits 0 and 3 enters at bit 9 while the value shifts right.
    function automatic int lstep(input int v);
        return (v >> 1) + ((((v ^ (v >> 3)) & 1) == 0) ? 512 : 0);
    endfunction

    task automatic model_edge(input int d, input int rq);
        int eff;
        int idx;
        if (reset) begin
            m_lfsr[d] = safe_seed(m_seed[d]);
            m_ptr[d] = 0; m_gnt[d] = 0; m_rand[d] = 0;
            m_valid[d] = 0; m_busy[d] = 0; m_reseed[d] = 0;
        end else if (m_reseed[d] != 0) begin
            m_reseed[d] = 0; m_busy[d] = 0; m_gnt[d] = 0; m_valid[d] = 0;
        end else if (seed_load) begin
            m_reseed[d] = 1; m_busy[d] = 1; m_gnt[d] = 0; m_valid[d] = 0;
            m_lfsr[d] = safe_seed(int'(seed_in));
        end else begin
            eff = rq & ~m_gnt[d];
            idx = -1;
            for (int k = 0; k < m_n[d]; k++) begin
                if (idx < 0 && ((eff >> ((m_ptr[d] + k) % m_n[d])) & 1) != 0) begin
                    idx = (m_ptr[d] + k) % m_n[d];
                end
            end
            m_busy[d] = 0;
            if (idx >= 0) begin
                m_gnt[d] = 1 << idx;
                m_rand[d] = m_lfsr[d];
                m_valid[d] = 1;
                m_lfsr[d] = lstep(m_lfsr[d]);
                m_ptr[d] = (idx + 1) % m_n[d];
            end else begin
                m_gnt[d] = 0;
                m_valid[d] = 0;
                if (m_free[d] != 0) m_lfsr[d] = lstep(m_lfsr[d]);
            end
        end
    endtask

    // Advance one clock, update the model with the sampled inputs, compare outputs.
    task automatic step();
        @(posedge clk);
        model_edge(0, int'(req4));
        model_edge(1, int'(req3));
        #1;
        check("gnt4",   32'(gnt4),   m_gnt[0]);
        check("rand4",  32'(rand4),  m_rand[0]);
        check("valid4", 32'(valid4), m_valid[0]);
        check("busy4",  32'(busy4),  m_busy[0]);
        check("gnt3",   32'(gnt3),   m_gnt[1]);
        check("rand3",  32'(rand3),  m_rand[1]);
        check("valid3", 32'(valid3), m_valid[1]);
        check("busy3",  32'(busy3),  m_busy[1]);
    endtask

    initial begin
        int found;
        for (int d = 0; d < 2; d++) begin
            m_lfsr[d] = 0; m_ptr[d] = 0; m_gnt[d] = 0; m_rand[d] = 0;
            m_valid[d] = 0; m_busy[d] = 0; m_reseed[d] = 0;
        end
        reset = 1'b1; req4 = '0; req3 = '0; seed_load = 1'b0; seed_in = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_gnt4", 32'(gnt4), 0);
        check("rst_valid4", 32'(valid4), 0);
        check("rst_rand4", 32'(rand4), 0);

        // Full request load: rotation and LFSR sequence from seed 000.
        req4 = 4'hF; req3 = 3'h7;
        for (int i = 0; i < 5; i++) begin
            step();
            check("seq_gnt4", 32'(gnt4), eg4[i]);
            check("seq_rand4", 32'(rand4), er4[i]);
            if (i < 4) check("seq_gnt3", 32'(gnt3), eg3[i]);
        end
        req4 = '0; req3 = '0;

        // Single requester pulsed until granted, then dropped.
        reset = 1'b1; step(); reset = 1'b0;
        req4 = 4'b0100; step();
        check("single_gnt", 32'(gnt4), 4);
        check("single_rand", 32'(rand4), 'h000);
        req4 = '0; step();
        check("single_drop", 32'(gnt4), 0);
        check("single_hold", 32'(rand4), 'h000);
        step(); step();
        req4 = 4'b0100; step();
        check("single_again", 32'(rand4), 'h200);
        req4 = '0; step();

        // Reseed to 11C; a second strobe during RESEED must be ignored.
        seed_load = 1'b1; seed_in = 10'h11C; req4 = 4'b0011; step();
        check("rs_busy", 32'(busy4), 1);
        check("rs_gnt", 32'(gnt4), 0);
        seed_in = 10'h055; step();
        seed_load = 1'b0;
        check("rs_busy_off", 32'(busy4), 0);
        check("rs_gnt_off", 32'(gnt4), 0);
        step();
        check("rs_gnt_a", 32'(gnt4), 1);
        check("rs_rand_a", 32'(rand4), 'h11C);
        step();
        check("rs_gnt_b", 32'(gnt4), 2);
        check("rs_rand_b", 32'(rand4), 'h08E);
        req4 = '0; step();

        // Lockup seed is substituted by 000.
        seed_load = 1'b1; seed_in = 10'h3FF; step();
        seed_load = 1'b0; step();
        req4 = 4'b0001; step();
        check("lock_gnt", 32'(gnt4), 1);
        check("lock_rand", 32'(rand4), 'h000);
        step();
        check("lock_mask", 32'(gnt4), 0);
        step();
        check("lock_gnt2", 32'(gnt4), 1);
        check("lock_rand2", 32'(rand4), 'h200);
        req4 = '0; step();

        // Reset while gnt=0010 is being driven.
        req4 = 4'hF; found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            step();
            if (gnt4 == 4'b0010) found = 1;
        end
        check("find_0010", 32'(found), 1);
        reset = 1'b1; step(); reset = 1'b0;
        check("midrst_gnt", 32'(gnt4), 0);
        check("midrst_valid", 32'(valid4), 0);
        step();
        check("midrst_first", 32'(gnt4), 1);
        check("midrst_rand", 32'(rand4), 'h000);
        req4 = '0; req3 = '0; step();

        // Randomized traffic with occasional reseeds and resets.
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            seed_load = ($urandom_range(0, 15) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
            req4      = 4'($urandom);
            req3      = 3'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
